// File: rtl/run_ctrl.sv
// run_ctrl: run/pause/step/halt CPU advance enable; define RUN_CTRL_BREAKPOINT_EN for a PC breakpoint in RUN
module run_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        halt_req,
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic        halted
);
    typedef enum logic [1:0] {PAUSE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALT = 2'b11} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    state_t     st;
    logic [1:0] raw, s0, s1, deb, deb_q;
    logic       run_p, step_p, bp_hit;
    assign raw = {btn_step, btn_run};
    always_ff @(posedge clk) begin
        if (rst) begin
            s0    <= '0;
            s1    <= '0;
            deb_q <= '0;
        end else begin
            s0    <= raw;
            s1    <= s0;
            deb_q <= deb;
        end
    end
    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             lvl;
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (s1[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                lvl <= ~lvl;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
        assign deb[i] = lvl;
    end
    assign run_p  = deb[0] & ~deb_q[0];
    assign step_p = deb[1] & ~deb_q[1];
`ifdef RUN_CTRL_BREAKPOINT_EN
    assign bp_hit = (pc == bp_addr) && (bp_addr != 32'hFFFF_FFFF);
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr};
    assign bp_hit    = 1'b0;
`endif
    assign cpu_en = !rst && !halt_req && ((st == RUN && tick) || st == STEP);
    assign state  = st;
    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= PAUSE;
            halted <= 1'b0;
        end else if (halt_req) begin
            st     <= HALT;
            halted <= 1'b1;
        end else begin
            case (st)
                PAUSE:   st <= run_p ? RUN : step_p ? STEP : PAUSE;
                RUN:     st <= (run_p || (tick && bp_hit)) ? PAUSE : RUN;
                STEP:    st <= PAUSE;
                default: st <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed scoreboard bench for run_ctrl
module tb_run_ctrl;
    localparam logic [1:0] PAUSE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALT = 2'b11;
    logic        clk = 0, rst, tick, btn_run, btn_step, halt_req, cpu_en, halted;
    logic [31:0] pc, bp_addr;
    logic [1:0]  state;
    int          cyc = 0, ncmp = 0, nfail = 0, n_en = 0;
    bit          last_en = 0, tick_on = 0;
    int          q_cyc[$];
    string       q_nm[$];
    logic [3:0]  q_exp[$];
    logic [3:0]  m_exp;
    string       m_nm;

    run_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_run(btn_run), .btn_step(btn_step),
        .halt_req(halt_req), .pc(pc), .bp_addr(bp_addr),
        .cpu_en(cpu_en), .state(state), .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
            void'(q_cyc.pop_front());
            m_exp = q_exp.pop_front();
            m_nm  = q_nm.pop_front();
            ncmp++;
            if ({state, cpu_en, halted} !== m_exp) begin
                nfail++;
                $display("FAIL %s cyc=%0d state/cpu_en/halted got=%b_%b_%b required=%b_%b_%b",
                         m_nm, cyc, state, cpu_en, halted, m_exp[3:2], m_exp[1], m_exp[0]);
            end
        end
    end

    task automatic tk();
        @(posedge clk);
        #1;
        if (last_en) begin
            pc = pc + 32'd4;
            n_en++;
        end
        tick = tick_on && (cyc % 4 == 0);
    endtask

    task automatic chk(input string nm, input logic [1:0] s, input bit zero = 0);
        logic en;
        en = !zero && (s == RUN ? tick : s == STEP);
        last_en = en;
        q_cyc.push_back(cyc);
        q_nm.push_back(nm);
        q_exp.push_back({s, en, s == HALT});
    endtask

    task automatic press(input bit stp, input int bounce, input int rel, input int n,
                         input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                         input int kf, input int ke, input string nm);
        bit b;
        for (int k = 0; k < n; k++) begin
            tk();
            b = (k < bounce) ? (k % 2 == 0) : (k < rel);
            if (stp) btn_step = b; else btn_run = b;
            chk(nm, k < kf ? s0 : k < ke ? s1 : s2);
        end
    endtask

    task automatic wait_tick(input string nm, input logic [1:0] s);
        tk();
        while (!tick) begin
            chk(nm, s);
            tk();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1; tick = 0; btn_run = 0; btn_step = 0; halt_req = 0;
        pc = 32'h0; bp_addr = 32'hFFFF_FFFF;
        repeat (3) begin tk(); chk("reset", PAUSE, 1); end
        tk(); rst = 0; chk("reset_rel", PAUSE);
        tick_on = 1;
        repeat (100) begin tk(); chk("idle", PAUSE); end
        press(0, 0, 40, 70, PAUSE, RUN, RUN, 19, 1000, "run_press");
        press(0, 0, 40, 70, RUN, PAUSE, PAUSE, 19, 1000, "pause_press");
        press(1, 3, 33, 60, PAUSE, STEP, PAUSE, 21, 22, "step_press");
`ifdef RUN_CTRL_BREAKPOINT_EN
        bp_addr = 32'h0000_3010; pc = 32'h0000_3000; n_en = 0;
        press(0, 0, 20, 20, PAUSE, RUN, RUN, 19, 1000, "bp_press");
        for (int i = 0; i < 40; i++) begin
            tk(); btn_run = 0;
            chk("bp_hit", n_en >= 5 ? PAUSE : RUN);
        end
        bp_addr = 32'hFFFF_FFFF; pc = 32'h0000_3000;
        press(0, 0, 20, 20, PAUSE, RUN, RUN, 19, 1000, "bp_off_press");
        for (int i = 0; i < 40; i++) begin
            tk(); btn_run = 0;
            chk("bp_off_run", RUN);
        end
        press(0, 0, 40, 60, RUN, PAUSE, PAUSE, 19, 1000, "bp_off_pause");
`endif
        press(0, 0, 40, 60, PAUSE, RUN, RUN, 19, 1000, "run_pre_halt");
        wait_tick("pre_halt", RUN);
        halt_req = 1; chk("halt_en0", RUN, 1);
        tk(); halt_req = 0; chk("halt_enter", HALT);
        press(0, 0, 40, 60, HALT, HALT, HALT, 0, 0, "halt_run_btn");
        press(1, 3, 33, 60, HALT, HALT, HALT, 0, 0, "halt_step_btn");
        tk(); rst = 1; chk("rst_in_halt", HALT, 1);
        tk(); rst = 0; chk("rst_halt_exit", PAUSE);
        press(0, 0, 40, 60, PAUSE, RUN, RUN, 19, 1000, "run_pre_rst");
        wait_tick("pre_rst", RUN);
        rst = 1; chk("rst_run_en0", RUN, 1);
        tk(); rst = 0; chk("rst_to_pause", PAUSE);
        repeat (20) begin tk(); chk("rst_stay_pause", PAUSE); end
        press(0, 0, 40, 60, PAUSE, RUN, RUN, 19, 1000, "run_resume");
        repeat (3) tk();
        if (q_cyc.size() != 0) begin
            nfail += q_cyc.size();
            $display("FAIL scoreboard_drain left=%0d required=0", q_cyc.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
